max7219_rx_decoder: RTL

Receive-side counterpart of the MAX7219 serial driver: it oversamples the 3-wire bus (CLK, DIN, LOAD) with the system clock and deserializes a daisy-chained frame of G_NB_MATRIX 16-bit words. It decodes each word into a per-matrix MAX7219 register file (digits 0-7 plus control registers) and exposes both the raw frame and a registered read port. It sits in the scroller benches next to the driver instance, and in the emulator, as a self-checking model of the display chain.

---
 rtl/max7219_rx_decoder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/max7219_rx_decoder.sv
// max7219_rx_decoder
//   Receive-side model of a daisy-chained MAX7219 display bus. The three bus
//   wires are oversampled with the system clock. Bits are shifted in on the
//   serial clock's rising edges, and the frame is checked and latched on the
//   LOAD rising edge. Each 16-bit word is decoded into that matrix's
//   register file.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   i_max7219_clk     serial clock (asynchronous to clk)
//   i_max7219_din     serial data, MSB first per word
//   i_max7219_load    latch strobe; rising edge ends a frame
//   o_frame_valid     1-cycle pulse, well-formed frame latched
//   o_frame_data      last good frame; word 0 (matrix 0) = last word shifted
//   o_frame_err       1-cycle pulse, malformed frame rejected
//   o_bit_count       bit count of the last frame (saturating)
//   i_rd_matrix       register-file read: matrix index
//   i_rd_addr         register-file read: MAX7219 register address
//   o_rd_data         registered read data (1-cycle latency)
module max7219_rx_decoder #(
  parameter int G_NB_MATRIX   = 8,
  parameter int G_SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_max7219_clk,
  input  logic                     i_max7219_din,
  input  logic                     i_max7219_load,
  output logic                     o_frame_valid,
  output logic [16*G_NB_MATRIX-1:0] o_frame_data,
  output logic                     o_frame_err,
  output logic [15:0]              o_bit_count,
  input  logic [3:0]               i_rd_matrix,
  input  logic [3:0]               i_rd_addr,
  output logic [7:0]               o_rd_data
);

  localparam int FRAME_W = 16 * G_NB_MATRIX;

  function automatic logic [15:0] sat_inc(input logic [15:0] n);
    return (n == 16'hFFFF) ? n : n + 16'd1;
  endfunction

  function automatic logic frame_good(input logic [15:0] n);
    return (n != 16'd0) && (n[3:0] == 4'd0) && (32'(n) <= FRAME_W);
  endfunction

  // Addresses 0x0 (no-op), 0xD and 0xE hold no register.
  function automatic logic addr_impl(input logic [3:0] a);
    return (a != 4'h0) && (a != 4'hD) && (a != 4'hE);
  endfunction

  logic [G_SYNC_STAGES-1:0] clk_sync_p0, din_sync_p0, load_sync_p0;
  logic                     clk_p1, load_p1;
  logic                     clk_rise, load_rise, din_bit;

  logic [FRAME_W-1:0] sr;
  logic [FRAME_W-1:0] sr_next;
  logic [15:0]        cnt;
  logic [15:0]        cnt_next;
  logic               frame_ok;
  logic [11:0]        n_words;

  // Rows beyond G_NB_MATRIX are never written and stay zero.
  logic [7:0] regs [16][16];

  // ---- stage p0: synchronizers; p1: edge history ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_p0  <= '0;
      din_sync_p0  <= '0;
      load_sync_p0 <= '0;
      clk_p1       <= 1'b0;
      load_p1      <= 1'b0;
    end else begin
      clk_sync_p0  <= {clk_sync_p0[G_SYNC_STAGES-2:0], i_max7219_clk};
      din_sync_p0  <= {din_sync_p0[G_SYNC_STAGES-2:0], i_max7219_din};
      load_sync_p0 <= {load_sync_p0[G_SYNC_STAGES-2:0], i_max7219_load};
      clk_p1       <= clk_sync_p0[G_SYNC_STAGES-1];
      load_p1      <= load_sync_p0[G_SYNC_STAGES-1];
    end
  end

  assign clk_rise  = clk_sync_p0[G_SYNC_STAGES-1] & ~clk_p1;
  assign load_rise = load_sync_p0[G_SYNC_STAGES-1] & ~load_p1;
  assign din_bit   = din_sync_p0[G_SYNC_STAGES-1];

  // A CLK rise coinciding with a LOAD rise is folded into the frame being
  // checked, so the check looks at the post-shift register and count.
  always_comb begin
    sr_next  = sr;
    cnt_next = cnt;
    if (clk_rise) begin
      sr_next  = {sr[FRAME_W-2:0], din_bit};
      cnt_next = sat_inc(cnt);
    end
  end

  assign frame_ok = frame_good(cnt_next);
  assign n_words  = cnt_next[15:4];

  // ---- stage p2: shift, frame check, outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr            <= '0;
      cnt           <= '0;
      o_frame_data  <= '0;
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      o_bit_count   <= '0;
    end else begin
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      sr            <= sr_next;
      cnt           <= cnt_next;
      if (load_rise) begin
        o_bit_count <= cnt_next;
        cnt         <= '0;
        if (frame_ok) begin
          o_frame_data  <= sr_next;
          o_frame_valid <= 1'b1;
        end else begin
          o_frame_err   <= 1'b1;
        end
      end
    end
  end

  // Only the last n_words words shifted (matrices 0..n_words-1) are decoded
  // on a short frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 16; m++)
        for (int a = 0; a < 16; a++)
          regs[m][a] <= '0;
    end else if (load_rise && frame_ok) begin
      for (int m = 0; m < G_NB_MATRIX; m++) begin
        if (m < int'(n_words) && addr_impl(sr_next[16*m+8 +: 4]))
          regs[m][sr_next[16*m+8 +: 4]] <= sr_next[16*m +: 8];
      end
    end
  end

  // ---- read port stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_data <= '0;
    end else if (int'(i_rd_matrix) < G_NB_MATRIX && addr_impl(i_rd_addr)) begin
      o_rd_data <= regs[i_rd_matrix][i_rd_addr];
    end else begin
      o_rd_data <= '0;
    end
  end

endmodule
